// File: rtl/modulo_sched_pkg.sv
// Shared types and helpers for the modulo counter scheduler.
// rr_pick is a round-robin first-set search used by the scheduler's arbiter.
package modulo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_MODULUS = 12;
  localparam int DEFAULT_NUM_REQ = 4;
  localparam int MAX_REQ         = 32;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } pick_t;

  // Search ptr, ptr+1, ... wrapping at n; only the low n request bits take part.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [31:0]        ptr,
                                    input logic [31:0]        n);
    pick_t       pick;
    logic [31:0] k;
    pick = '0;
    k    = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (32'(i) < n && !pick.found) begin
        k = ptr + 32'(i);
        if (k >= n) k = k - n;
        if (req[k[4:0]]) begin
          pick.found = 1'b1;
          pick.idx   = k;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mod_counter_en.sv
// Modulo-MODULUS up counter with synchronous clear and count enable.
// Clear has priority over enable.
module mod_counter_en #(
  parameter int MODULUS = 12,
  parameter int CW      = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] res
);

  localparam logic [CW-1:0] MAX_VAL = CW'(MODULUS - 1);

  logic [CW-1:0] res_q;
  logic [CW-1:0] res_d;

  always_comb begin
    res_d = res_q;
    if (clear) begin
      res_d = '0;
    end else if (enable) begin
      res_d = (res_q == MAX_VAL) ? '0 : res_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/modulo_counter_scheduler.sv
// Round-robin scheduler sharing one modulo counter between NUM_REQ requesters.
// Each granted run clears the counter, counts 0..target, then pulses done to the owner.
module modulo_counter_scheduler
  import modulo_sched_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  parameter  int MODULUS = DEFAULT_MODULUS,
  localparam int CW      = $clog2(MODULUS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*CW-1:0] target,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [CW-1:0]         res
);

  localparam int            IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] MAX_VAL = CW'(MODULUS - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     tgt_q, tgt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic              busy_q, busy_d;

  pick_t         pick;
  logic [IW-1:0] pick_idx;
  logic [CW-1:0] tgt_raw;
  logic          cnt_clear;
  logic          cnt_en;

  mod_counter_en #(
    .MODULUS (MODULUS),
    .CW      (CW)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .res    (res)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    tgt_d     = tgt_q;
    grant_d   = grant_q;
    done_d    = '0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    pick     = rr_pick(MAX_REQ'(req), 32'(rr_ptr_q), 32'(NUM_REQ));
    pick_idx = IW'(pick.idx);
    tgt_raw  = target[pick_idx*CW +: CW];

    case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (pick.found) begin
          state_d           = RUN;
          idx_d             = pick_idx;
          tgt_d             = (tgt_raw > MAX_VAL) ? MAX_VAL : tgt_raw;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      RUN: begin
        // Owner dropping its request aborts silently; the pointer stays put.
        if (!req[idx_q]) begin
          state_d   = IDLE;
          grant_d   = '0;
          cnt_clear = 1'b1;
        end else if (res == tgt_q) begin
          state_d       = DONE;
          done_d[idx_q] = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        grant_d   = '0;
        cnt_clear = 1'b1;
        rr_ptr_d  = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        cnt_clear = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      tgt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      tgt_q    <= tgt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_modulo_counter_scheduler.sv
// Directed bench for modulo_counter_scheduler (NUM_REQ=4, MODULUS=12).
// Expected grant/res/done sequences are hand-derived from the scheduler behaviour.
module tb_modulo_counter_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] target;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  res;

  int check_count = 0;
  int error_count = 0;

  modulo_counter_scheduler #(
    .NUM_REQ (4),
    .MODULUS (12)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .target (target),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .res    (res)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] new_req, input logic [15:0] new_target);
    req    = new_req;
    target = new_target;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".grant"}, 32'(grant), 32'h0);
    checkOutput({tag, ".done"},  32'(done),  32'h0);
    checkOutput({tag, ".busy"},  32'(busy),  32'h0);
    checkOutput({tag, ".res"},   32'(res),   32'h0);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    checkIdle("rst");
    reset = 1'b0;
  endtask

  // Full run from IDLE: tgt+1 RUN cycles, one DONE cycle, then one IDLE cycle.
  task automatic runCheck(input int owner, input int last, input bit drop);
    logic [31:0] oh;
    oh = 32'(1) << owner;
    for (int k = 0; k <= last; k++) begin
      tick();
      checkOutput("run.grant", 32'(grant), oh);
      checkOutput("run.res",   32'(res),   32'(k));
      checkOutput("run.done",  32'(done),  32'h0);
      checkOutput("run.busy",  32'(busy),  32'h1);
    end
    tick();
    checkOutput("done.done",  32'(done),  oh);
    checkOutput("done.grant", 32'(grant), oh);
    checkOutput("done.res",   32'(res),   32'(last));
    checkOutput("done.busy",  32'(busy),  32'h1);
    if (drop) req[owner] = 1'b0;
    tick();
    checkIdle("post");
  endtask

  initial begin
    reset  = 1'b1;
    req    = 4'b0000;
    target = 16'h0000;

    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdle("reset_hold");
    end
    reset = 1'b0;
    tick();
    checkIdle("reset_release");

    applyStimulus(4'b0001, {4'd0, 4'd0, 4'd0, 4'd5});
    runCheck(0, 5, 1'b1);

    // Fresh pointer so requester 0 wins the simultaneous pair.
    applyReset();
    applyStimulus(4'b0101, {4'd0, 4'd11, 4'd0, 4'd3});
    runCheck(0, 3, 1'b1);
    runCheck(2, 11, 1'b1);

    applyStimulus(4'b0010, {4'd0, 4'd0, 4'd15, 4'd0});
    runCheck(1, 11, 1'b1);

    // Pointer is 2: requester 0 wins, stays high, and must queue behind requester 1.
    applyStimulus(4'b0011, 16'h0000);
    runCheck(0, 0, 1'b0);
    runCheck(1, 0, 1'b1);
    runCheck(0, 0, 1'b1);

    applyStimulus(4'b1000, {4'd9, 4'd0, 4'd0, 4'd0});
    for (int k = 0; k <= 4; k++) begin
      tick();
      checkOutput("abort.grant", 32'(grant), 32'h8);
      checkOutput("abort.res",   32'(res),   32'(k));
      if (k == 1) req[1] = 1'b1;
      if (k == 3) req[1] = 1'b0;
    end
    req[3] = 1'b0;
    tick();
    checkIdle("abort");
    tick();
    checkIdle("abort.stay");

    // Pointer is 1 here, so requester 2 owns the run that reset interrupts.
    applyStimulus(4'b0100, {4'd0, 4'd9, 4'd0, 4'd0});
    for (int k = 0; k <= 6; k++) begin
      tick();
      checkOutput("midrst.grant", 32'(grant), 32'h4);
      checkOutput("midrst.res",   32'(res),   32'(k));
    end
    reset = 1'b1;
    req   = 4'b0101;
    tick();
    checkIdle("midrst");
    reset = 1'b0;
    tick();
    checkOutput("rearb.grant", 32'(grant), 32'h1);
    checkOutput("rearb.res",   32'(res),   32'h0);
    checkOutput("rearb.busy",  32'(busy),  32'h1);
    req = 4'b0000;
    tick();
    checkIdle("final");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
